// File: rtl/bus_arbiter_split_pkg.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_split_pkg
// Description : Shared definitions for the two-master split-capable arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package bus_arbiter_split_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_GRANT1 = 2'd1,
        ST_GRANT2 = 2'd2
    } arb_state_t;

    localparam logic MID_M1 = 1'b0;
    localparam logic MID_M2 = 1'b1;

    localparam int SPLIT_TIMEOUT_DEFAULT = 1024;

endpackage
`default_nettype wire

// File: rtl/bus_arbiter_split_if.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_split_if
// Description : Request/grant/split signals between masters and the arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
interface bus_arbiter_split_if;

    logic m1_breq;
    logic m2_breq;
    logic m1_bgrant;
    logic m2_bgrant;
    logic msel;
    logic m1_split;
    logic m2_split;
    logic split_req;
    logic split_done;
    logic split_grant;

    modport master (
        output m1_breq, m2_breq, split_req, split_done,
        input  m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant
    );

    modport slave (
        input  m1_breq, m2_breq, split_req, split_done,
        output m1_bgrant, m2_bgrant, msel, m1_split, m2_split, split_grant
    );

endinterface
`default_nettype wire

// File: rtl/bus_arbiter_split_split_tracker.sv
`default_nettype none
// ============================================================================
// Module      : split_tracker
// Description : Single split slot: parked owner, sticky done latch, timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module split_tracker
    import bus_arbiter_split_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = SPLIT_TIMEOUT_DEFAULT
) (
    input  wire logic       clk,
    input  wire logic       rstn,
    input  wire logic       split_set,
    input  wire logic       split_id,
    input  wire logic       resume_ack,
    input  wire logic [1:0] breq,
    input  wire logic       split_done,
    output logic            resume_req,
    output logic            owner,
    output logic [1:0]      parked
);

    localparam int              CW         = $clog2(SPLIT_TIMEOUT + 1);
    localparam logic [CW-1:0]   C_CNT_LAST = CW'(SPLIT_TIMEOUT - 1);

    logic          r_pending;
    logic          r_owner;
    logic          r_done_seen;
    logic [CW-1:0] r_cnt;

    logic w_owner_breq;
    logic w_cancel;
    logic w_expire;

    assign w_owner_breq = breq[r_owner];
    assign w_cancel     = r_pending & ~w_owner_breq;
    assign w_expire     = r_pending & (r_cnt == C_CNT_LAST);

    // A master that has already let go of its request is never resumed.
    assign resume_req = r_pending & w_owner_breq & (r_done_seen | split_done);
    assign owner      = r_owner;
    assign parked     = {r_pending & r_owner, r_pending & ~r_owner};

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_pending   <= 1'b0;
            r_owner     <= MID_M1;
            r_done_seen <= 1'b0;
            r_cnt       <= '0;
        end else if (split_set) begin
            r_pending   <= 1'b1;
            r_owner     <= split_id;
            r_done_seen <= 1'b0;
            r_cnt       <= '0;
        end else if (r_pending) begin
            if (resume_ack || w_cancel || w_expire) begin
                r_pending   <= 1'b0;
                r_done_seen <= 1'b0;
                r_cnt       <= '0;
            end else begin
                r_done_seen <= r_done_seen | split_done;
                r_cnt       <= r_cnt + CW'(1);
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/bus_arbiter_split.sv
`default_nettype none
// ============================================================================
// Module      : bus_arbiter_split
// Description : Round-robin two-master bus arbiter with one split slot.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_arbiter_split
    import bus_arbiter_split_pkg::*;
#(
    parameter int SPLIT_TIMEOUT = SPLIT_TIMEOUT_DEFAULT
) (
    input  wire logic     clk,
    input  wire logic     rstn,
    bus_arbiter_split_if.slave bus
);

    arb_state_t r_state;
    arb_state_t w_state_nxt;
    logic       r_last;
    logic       r_msel;
    logic       r_m1_bgrant;
    logic       r_m2_bgrant;
    logic       r_split_grant;

    logic       w_take;
    logic       w_take_id;
    logic       w_resume_ack;
    logic       w_split_set;
    logic       w_split_id;
    logic       w_resume_req;
    logic       w_owner;
    logic [1:0] w_parked;
    logic [1:0] w_req;
    logic       w_pending;

    split_tracker #(
        .SPLIT_TIMEOUT (SPLIT_TIMEOUT)
    ) u_split_tracker (
        .clk        (clk),
        .rstn       (rstn),
        .split_set  (w_split_set),
        .split_id   (w_split_id),
        .resume_ack (w_resume_ack),
        .breq       ({bus.m2_breq, bus.m1_breq}),
        .split_done (bus.split_done),
        .resume_req (w_resume_req),
        .owner      (w_owner),
        .parked     (w_parked)
    );

    assign w_pending = |w_parked;
    assign w_req     = {bus.m2_breq, bus.m1_breq} & ~w_parked;

    always_comb begin
        w_state_nxt  = r_state;
        w_take       = 1'b0;
        w_take_id    = r_last;
        w_resume_ack = 1'b0;
        w_split_set  = 1'b0;
        w_split_id   = MID_M1;
        case (r_state)
            ST_IDLE: begin
                if (w_resume_req) begin
                    w_take       = 1'b1;
                    w_take_id    = w_owner;
                    w_resume_ack = 1'b1;
                end else if (&w_req) begin
                    w_take    = 1'b1;
                    w_take_id = ~r_last;
                end else if (w_req[0]) begin
                    w_take    = 1'b1;
                    w_take_id = MID_M1;
                end else if (w_req[1]) begin
                    w_take    = 1'b1;
                    w_take_id = MID_M2;
                end
                if (w_take) begin
                    w_state_nxt = (w_take_id == MID_M2) ? ST_GRANT2 : ST_GRANT1;
                end
            end
            ST_GRANT1: begin
                if (!bus.m1_breq) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.split_req && !w_pending) begin
                    w_state_nxt = ST_IDLE;
                    w_split_set = 1'b1;
                    w_split_id  = MID_M1;
                end
            end
            ST_GRANT2: begin
                if (!bus.m2_breq) begin
                    w_state_nxt = ST_IDLE;
                end else if (bus.split_req && !w_pending) begin
                    w_state_nxt = ST_IDLE;
                    w_split_set = 1'b1;
                    w_split_id  = MID_M2;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    // Grants are flopped from the next state so they never glitch.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state       <= ST_IDLE;
            r_last        <= MID_M2;
            r_msel        <= MID_M1;
            r_m1_bgrant   <= 1'b0;
            r_m2_bgrant   <= 1'b0;
            r_split_grant <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_m1_bgrant   <= (w_state_nxt == ST_GRANT1);
            r_m2_bgrant   <= (w_state_nxt == ST_GRANT2);
            r_split_grant <= w_resume_ack;
            if (w_take) begin
                r_last <= w_take_id;
                r_msel <= w_take_id;
            end
        end
    end

    assign bus.m1_bgrant   = r_m1_bgrant;
    assign bus.m2_bgrant   = r_m2_bgrant;
    assign bus.msel        = r_msel;
    assign bus.m1_split    = w_parked[0];
    assign bus.m2_split    = w_parked[1];
    assign bus.split_grant = r_split_grant;

endmodule
`default_nettype wire

// File: tb/tb_bus_arbiter_split.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_arbiter_split
// Description : Randomized bench for bus_arbiter_split against a cycle model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_arbiter_split;

    localparam int TMO      = 8;
    localparam int N_CYCLES = 4000;

    logic clk;
    logic rstn;

    bus_arbiter_split_if bus ();

    bus_arbiter_split #(
        .SPLIT_TIMEOUT (TMO)
    ) dut (
        .clk  (clk),
        .rstn (rstn),
        .bus  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference state: owner/parked are master numbers 1/2, 0 = none.
    int m_own, m_last, m_msel, m_park, m_age;
    bit m_seen, m_sg;

    // Stimulus-side master behaviour.
    bit req1, req2;
    int len1, len2;
    int since_rst;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", tag, $time, got, exp);
        end
    endtask

    task automatic model_reset();
        m_own = 0; m_last = 2; m_msel = 0; m_park = 0; m_age = 0;
        m_seen = 1'b0; m_sg = 1'b0;
    endtask

    task automatic model_step(input bit b1, input bit b2, input bit sr, input bit sd);
        bit breq [3];
        int own, park;
        bit resume, set_now, r1, r2;
        breq[0] = 1'b0; breq[1] = b1; breq[2] = b2;
        own = m_own; park = m_park; set_now = 1'b0;
        resume = (own == 0) && (park != 0) && breq[park] && (m_seen || sd);
        m_sg = 1'b0;
        if (own == 0) begin
            if (resume) begin
                m_own = park;
                m_sg  = 1'b1;
            end else begin
                r1 = b1 && (park != 1);
                r2 = b2 && (park != 2);
                if (r1 && r2)  m_own = (m_last == 1) ? 2 : 1;
                else if (r1)   m_own = 1;
                else if (r2)   m_own = 2;
            end
            if (m_own != 0) begin
                m_last = m_own;
                m_msel = m_own - 1;
            end
        end else if (!breq[own]) begin
            m_own = 0;
        end else if (sr && park == 0) begin
            m_own = 0; m_park = own; m_age = 0; m_seen = 1'b0; set_now = 1'b1;
        end
        if (!set_now && park != 0) begin
            if (resume || !breq[park] || m_age == TMO - 1) begin
                m_park = 0; m_seen = 1'b0;
            end else begin
                m_age++;
                m_seen = m_seen | sd;
            end
        end
    endtask

    task automatic check_outputs(input string tag);
        check({tag, ".m1_bgrant"},   32'(bus.m1_bgrant),   32'(m_own == 1));
        check({tag, ".m2_bgrant"},   32'(bus.m2_bgrant),   32'(m_own == 2));
        check({tag, ".msel"},        32'(bus.msel),        32'(m_msel));
        check({tag, ".m1_split"},    32'(bus.m1_split),    32'(m_park == 1));
        check({tag, ".m2_split"},    32'(bus.m2_split),    32'(m_park == 2));
        check({tag, ".split_grant"}, 32'(bus.split_grant), 32'(m_sg));
    endtask

    task automatic drive_master(inout bit req, inout int len, input int id);
        if (!req) begin
            if ($urandom_range(2, 0) == 0) begin
                req = 1'b1;
                len = $urandom_range(5, 1);
            end
        end else if (m_own == id) begin
            len--;
            if (len == 0) req = 1'b0;
        end else if (m_park == id) begin
            if ($urandom_range(19, 0) == 0) req = 1'b0;
        end
    endtask

    task automatic apply_inputs();
        bus.m1_breq    = req1;
        bus.m2_breq    = req2;
        bus.split_req  = ($urandom_range(4, 0) == 0);
        bus.split_done = ($urandom_range(11, 0) == 0);
    endtask

    initial begin
        rstn = 1'b0;
        req1 = 1'b1; req2 = 1'b1;
        len1 = 3;   len2 = 3;
        bus.m1_breq = 1'b0; bus.m2_breq = 1'b0;
        bus.split_req = 1'b0; bus.split_done = 1'b0;
        model_reset();
        @(posedge clk);
        #1;
        check_outputs("reset");
        @(negedge clk);
        rstn = 1'b1;
        apply_inputs();
        since_rst = 0;

        for (int cyc = 0; cyc < N_CYCLES; cyc++) begin
            @(posedge clk);
            model_step(bus.m1_breq, bus.m2_breq, bus.split_req, bus.split_done);
            #1;
            check_outputs("run");
            if (since_rst == 0) check("post_reset_contention", 32'(bus.m1_bgrant), 32'd1);
            since_rst++;
            drive_master(req1, len1, 1);
            drive_master(req2, len2, 2);
            apply_inputs();

            // Asynchronous reset dropped mid-cycle, preferably mid-transaction.
            if (since_rst > 300 && m_own != 0 && $urandom_range(9, 0) == 0) begin
                #2;
                rstn = 1'b0;
                #1;
                model_reset();
                check_outputs("async_reset");
                req1 = 1'b1; req2 = 1'b1;
                len1 = $urandom_range(5, 1);
                len2 = $urandom_range(5, 1);
                @(negedge clk);
                rstn = 1'b1;
                apply_inputs();
                bus.split_req = 1'b0;
                since_rst = 0;
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
`default_nettype wire
